axis_width_downsizer_pipe: RTL

Parametrised AXI4-Stream data-width downsizer. It splits each wide slave beat into RATIO = S_DATA_WIDTH/M_DATA_WIDTH narrow master beats, with zero-bubble back-to-back operation and null-lane skipping. TID/TDEST/TUSER are carried per beat. It sits between wide datapath engines and narrow egress/peripheral stream ports.

---
 rtl/axis_dwc_pkg.sv | 43 ++++
 rtl/axis_lane_pick.sv | 51 +++++
 rtl/axis_width_downsizer_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axis_dwc_pkg.sv
// Shared helpers for the AXI4-Stream width downsizer: lane arithmetic and the
// null-lane mask used to decide which narrow lanes are emitted.
package axis_dwc_pkg;

    localparam int KEEP_MAX   = 128;
    localparam int LANE_MAX   = 128;
    localparam int KEEP_IDX_W = 7;

    function automatic int lane_count(input int s, input int m);
        return (m > 0) ? (s / m) : 1;
    endfunction

    function automatic bit widths_ok(input int s, input int m);
        return (m >= 8) && (m % 8 == 0) && (s >= m) && (s % m == 0) && (s / 8 <= KEEP_MAX);
    endfunction

    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Bit n set when lane n (lane_bytes keep bits wide) carries no valid byte
    function automatic logic [LANE_MAX-1:0] null_lane_mask(
        input logic [KEEP_MAX-1:0] keep,
        input int                  lane_bytes,
        input int                  lanes
    );
        logic [LANE_MAX-1:0] any_set;
        logic [LANE_MAX-1:0] nul;
        any_set = '0;
        nul     = '0;
        for (int b = 0; b < KEEP_MAX; b++) begin
            if ((lane_bytes > 0) && (b < lanes * lane_bytes)) begin
                any_set[KEEP_IDX_W'(b / lane_bytes)] = any_set[KEEP_IDX_W'(b / lane_bytes)]
                                                     | keep[KEEP_IDX_W'(b)];
            end
        end
        for (int l = 0; l < LANE_MAX; l++) begin
            nul[KEEP_IDX_W'(l)] = (l < lanes) && !any_set[KEEP_IDX_W'(l)];
        end
        return nul;
    endfunction

endpackage

// File: rtl/axis_lane_pick.sv
// Priority encoder choosing which lanes of a wide beat are emitted.
// AXIS_DWN_SKIP_NULL_EN: also skip interior null lanes, not just trailing ones.
module axis_lane_pick
    import axis_dwc_pkg::*;
#(
    parameter int RATIO = 8,
    parameter int IDX_W = 3
) (
    input  logic [RATIO-1:0] i_nonnull,
    input  logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] o_first_lane,
    output logic [IDX_W-1:0] o_next_lane,
    output logic [IDX_W-1:0] o_last_lane,
    output logic             o_final
);

    logic [IDX_W-1:0] w_last;

    // Highest non-null lane; lane 0 when the beat carries no bytes at all
    always_comb begin
        w_last = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_last = i_nonnull[i] ? IDX_W'(i) : w_last;
        end
    end

`ifdef AXIS_DWN_SKIP_NULL_EN
    logic [IDX_W-1:0] w_low;
    logic [IDX_W-1:0] w_above;

    // Lowest non-null lane overall and lowest non-null lane above i_idx
    always_comb begin
        w_low   = '0;
        w_above = i_idx;
        for (int i = RATIO - 1; i >= 0; i--) begin
            w_low   = i_nonnull[i] ? IDX_W'(i) : w_low;
            w_above = (i_nonnull[i] && (IDX_W'(i) > i_idx)) ? IDX_W'(i) : w_above;
        end
    end

    assign o_first_lane = w_low;
    assign o_next_lane  = w_above;
`else
    assign o_first_lane = '0;
    assign o_next_lane  = i_idx + IDX_W'(1);
`endif

    assign o_last_lane = w_last;
    assign o_final     = (i_idx == w_last);

endmodule

// File: rtl/axis_width_downsizer_pipe.sv
// AXI4-Stream downsizer: one wide beat becomes up to RATIO narrow beats, no bubbles.
// AXIS_DWN_SKIP_NULL_EN (in axis_lane_pick) selects interior null-lane skipping.
module axis_width_downsizer_pipe
    import axis_dwc_pkg::*;
#(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 8,
    parameter int ID_WIDTH     = 1,
    parameter int DEST_WIDTH   = 1,
    parameter int USER_WIDTH   = 1,
    parameter int ID_EN        = 0,
    parameter int DEST_EN      = 0,
    parameter int USER_EN      = 0
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [ID_WIDTH-1:0]       s_axis_tid,
    input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [ID_WIDTH-1:0]       m_axis_tid,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest,
    output logic [USER_WIDTH-1:0]     m_axis_tuser
);

    localparam int RATIO    = lane_count(S_DATA_WIDTH, M_DATA_WIDTH);
    localparam int IDX_W    = idx_width(RATIO);
    localparam int S_KEEP_W = S_DATA_WIDTH / 8;
    localparam int M_KEEP_W = M_DATA_WIDTH / 8;

    if (!widths_ok(S_DATA_WIDTH, M_DATA_WIDTH)) begin : g_width_check
        $error("axis_width_downsizer_pipe: S_DATA_WIDTH must be a multiple of M_DATA_WIDTH, itself a multiple of 8");
    end

    logic [S_DATA_WIDTH-1:0] r_data;
    logic [S_KEEP_W-1:0]     r_keep;
    logic                    r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_hold_valid;
    logic [IDX_W-1:0]        r_idx;

    logic [RATIO-1:0]        w_hold_nonnull;
    logic [RATIO-1:0]        w_in_nonnull;
    logic [IDX_W-1:0]        w_in_first_lane;
    logic [IDX_W-1:0]        w_next_lane;
    logic [IDX_W-1:0]        w_last_lane;
    logic                    w_final;
    logic                    w_in_any;
    logic                    w_accept;
    logic                    w_m_hs;
    logic [M_DATA_WIDTH-1:0] w_lane_data;
    logic [M_KEEP_W-1:0]     w_lane_keep;

    logic [IDX_W-1:0]        w_unused_hold_first;
    logic [IDX_W-1:0]        w_unused_in_next;
    logic [IDX_W-1:0]        w_unused_in_last;
    logic                    w_unused_in_final;
    logic                    w_unused_sideband;

    // Sideband inputs are ignored when their enable is off
    assign w_unused_sideband = ^{s_axis_tid, s_axis_tdest, s_axis_tuser};

    assign w_hold_nonnull = RATIO'(~null_lane_mask(KEEP_MAX'(r_keep), M_KEEP_W, RATIO));
    assign w_in_nonnull   = RATIO'(~null_lane_mask(KEEP_MAX'(s_axis_tkeep), M_KEEP_W, RATIO));
    assign w_in_any       = |s_axis_tkeep;

    axis_lane_pick #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_pick_hold (
        .i_nonnull    (w_hold_nonnull),
        .i_idx        (r_idx),
        .o_first_lane (w_unused_hold_first),
        .o_next_lane  (w_next_lane),
        .o_last_lane  (w_last_lane),
        .o_final      (w_final)
    );

    axis_lane_pick #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_pick_in (
        .i_nonnull    (w_in_nonnull),
        .i_idx        ({IDX_W{1'b0}}),
        .o_first_lane (w_in_first_lane),
        .o_next_lane  (w_unused_in_next),
        .o_last_lane  (w_unused_in_last),
        .o_final      (w_unused_in_final)
    );

    // A new beat may enter in the same cycle the last lane of the held beat leaves
    assign s_axis_tready = areset_n && (!r_hold_valid || (m_axis_tready && w_final));
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_m_hs        = r_hold_valid && m_axis_tready;

    // Select the current lane's bytes from the holding register
    always_comb begin
        w_lane_data = '0;
        w_lane_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_lane_data = (r_idx == IDX_W'(i)) ? r_data[i*M_DATA_WIDTH +: M_DATA_WIDTH] : w_lane_data;
            w_lane_keep = (r_idx == IDX_W'(i)) ? r_keep[i*M_KEEP_W +: M_KEEP_W] : w_lane_keep;
        end
    end

    assign m_axis_tvalid = r_hold_valid;
    assign m_axis_tdata  = r_hold_valid ? w_lane_data : '0;
    assign m_axis_tkeep  = r_hold_valid ? w_lane_keep : '0;
    assign m_axis_tlast  = r_hold_valid && r_last && w_final;
    assign m_axis_tid    = r_hold_valid ? r_id : '0;
    assign m_axis_tdest  = r_hold_valid ? r_dest : '0;
    assign m_axis_tuser  = r_hold_valid ? r_user : '0;

    // Holding register: load on accept, step through lanes on master handshakes
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_data       <= '0;
            r_keep       <= '0;
            r_last       <= 1'b0;
            r_id         <= '0;
            r_dest       <= '0;
            r_user       <= '0;
            r_hold_valid <= 1'b0;
            r_idx        <= '0;
        end else if (w_accept) begin
            // An empty beat survives only to carry a packet boundary
            r_hold_valid <= w_in_any || s_axis_tlast;
            r_idx        <= w_in_first_lane;
            r_data       <= w_in_any ? s_axis_tdata : '0;
            r_keep       <= s_axis_tkeep;
            r_last       <= s_axis_tlast;
            r_id         <= (ID_EN != 0) ? s_axis_tid : '0;
            r_dest       <= (DEST_EN != 0) ? s_axis_tdest : '0;
            r_user       <= (USER_EN != 0) ? s_axis_tuser : '0;
        end else if (w_m_hs) begin
            if (w_final) begin
                r_hold_valid <= 1'b0;
                r_idx        <= '0;
            end else begin
                r_idx        <= w_next_lane;
            end
        end
    end

endmodule
